// File: rtl/axi_chk_pkg.sv
// Shared definitions for the passive AXI4 protocol checker: rule indices,
// tracked-burst record and burst-type encoding.
package axi_chk_pkg;

  localparam int CHK_AW_STABLE = 0;
  localparam int CHK_W_STABLE  = 1;
  localparam int CHK_AR_STABLE = 2;
  localparam int CHK_R_STABLE  = 3;
  localparam int CHK_B_STABLE  = 4;
  localparam int CHK_WLAST     = 5;
  localparam int CHK_W_NO_AW   = 6;
  localparam int CHK_RLAST     = 7;
  localparam int CHK_R_ORDER   = 8;
  localparam int CHK_B_ORDER   = 9;
  localparam int CHK_OVERFLOW  = 10;
  localparam int NUM_CHECKS    = 11;

  // IDs are zero-extended into a fixed-width field so one record type serves any ID_W <= 16
  localparam int CHK_ID_MAX_W  = 16;

  typedef struct packed {
    logic [CHK_ID_MAX_W-1:0] id;
    logic [7:0]              len;
  } burst_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

endpackage

// File: rtl/axi_assertion_checker_if.sv
// AXI4 five-channel signal bundle with master, slave and passive monitor views.
interface axi_assertion_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) ();

  logic              awvalid, awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid, wready, wlast;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;

  logic              bvalid, bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  logic              arvalid, arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready, rlast;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rid, rdata, rresp, rlast
  );

  modport monitor (
    input awvalid, awready, awid, awaddr, awlen, awsize, awburst,
    input wvalid, wready, wdata, wstrb, wlast,
    input bvalid, bready, bid, bresp,
    input arvalid, arready, arid, araddr, arlen, arsize, arburst,
    input rvalid, rready, rid, rdata, rresp, rlast
  );

endinterface

// File: rtl/axi_chk_fifo.sv
// Synchronous FIFO of burst records used to track outstanding bursts.
// Push while full is accepted only when a pop frees a slot on the same edge.
module axi_chk_fifo
  import axi_chk_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  burst_t push_data,
  input  logic   pop,
  output burst_t head,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;
  burst_t           mem_q [DEPTH];

  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == FULL_CNT);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    head     = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/axi_assertion_checker.sv
// Passive AXI4 protocol checker: evaluates handshake stability, burst length,
// ordering and tracking-depth rules every edge and reports sticky flags/pulse/count.
module axi_assertion_checker
  import axi_chk_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_assertion_checker_if.monitor bus,
  output logic [NUM_CHECKS-1:0] err_flags,
  output logic                  err_pulse,
  output logic [15:0]           err_count
);

  localparam int AX_PL_W = ID_W + ADDR_W + 13;
  localparam int W_PL_W  = DATA_W + DATA_W/8 + 1;
  localparam int R_PL_W  = ID_W + DATA_W + 3;
  localparam int B_PL_W  = ID_W + 2;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_pend_q, w_pend_q, b_pend_q, ar_pend_q, r_pend_q;
  logic aw_pend_d, w_pend_d, b_pend_d, ar_pend_d, r_pend_d;
  logic [AX_PL_W-1:0] aw_pl_d, aw_pl_q, ar_pl_d, ar_pl_q;
  logic [W_PL_W-1:0]  w_pl_d, w_pl_q;
  logic [R_PL_W-1:0]  r_pl_d, r_pl_q;
  logic [B_PL_W-1:0]  b_pl_d, b_pl_q;
  logic [7:0]  w_beat_q, w_beat_d, r_beat_q, r_beat_d;
  logic [NUM_CHECKS-1:0] fire, flags_q, flags_d;
  logic        pulse_q, pulse_d;
  logic [15:0] count_q, count_d;

  burst_t aw_head, b_head, ar_head, aw_cur, ar_cur, b_push_data, b_expect, aw_push_data, ar_push_data;
  logic aw_full, aw_empty, b_full, b_empty, ar_full, ar_empty;
  logic aw_push, aw_pop, b_push, b_pop, ar_push, ar_pop;
  logic w_done, r_done, aw_over, ar_over;

  axi_chk_fifo #(.DEPTH(MAX_OUT)) aw_q (
    .clk(clk), .rst(rst), .push(aw_push), .push_data(aw_push_data), .pop(aw_pop),
    .head(aw_head), .full(aw_full), .empty(aw_empty)
  );

  axi_chk_fifo #(.DEPTH(MAX_OUT)) b_q (
    .clk(clk), .rst(rst), .push(b_push), .push_data(b_push_data), .pop(b_pop),
    .head(b_head), .full(b_full), .empty(b_empty)
  );

  axi_chk_fifo #(.DEPTH(MAX_OUT)) ar_q (
    .clk(clk), .rst(rst), .push(ar_push), .push_data(ar_push_data), .pop(ar_pop),
    .head(ar_head), .full(ar_full), .empty(ar_empty)
  );

  always_comb begin
    aw_hs = bus.awvalid & bus.awready;
    w_hs  = bus.wvalid  & bus.wready;
    b_hs  = bus.bvalid  & bus.bready;
    ar_hs = bus.arvalid & bus.arready;
    r_hs  = bus.rvalid  & bus.rready;

    aw_pl_d = {bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst};
    ar_pl_d = {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst};
    w_pl_d  = {bus.wdata, bus.wstrb, bus.wlast};
    r_pl_d  = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
    b_pl_d  = {bus.bid, bus.bresp};
    aw_pend_d = bus.awvalid & ~bus.awready;
    w_pend_d  = bus.wvalid  & ~bus.wready;
    b_pend_d  = bus.bvalid  & ~bus.bready;
    ar_pend_d = bus.arvalid & ~bus.arready;
    r_pend_d  = bus.rvalid  & ~bus.rready;

    fire = '0;
    fire[CHK_AW_STABLE] = aw_pend_q && (!bus.awvalid || aw_pl_d != aw_pl_q);
    fire[CHK_W_STABLE]  = w_pend_q  && (!bus.wvalid  || w_pl_d  != w_pl_q);
    fire[CHK_AR_STABLE] = ar_pend_q && (!bus.arvalid || ar_pl_d != ar_pl_q);
    fire[CHK_R_STABLE]  = r_pend_q  && (!bus.rvalid  || r_pl_d  != r_pl_q);
    fire[CHK_B_STABLE]  = b_pend_q  && (!bus.bvalid  || b_pl_d  != b_pl_q);

    // An address accepted on the same edge as the first data beat stands in for an empty queue head
    aw_push_data.id  = CHK_ID_MAX_W'(bus.awid);
    aw_push_data.len = bus.awlen;
    ar_push_data.id  = CHK_ID_MAX_W'(bus.arid);
    ar_push_data.len = bus.arlen;
    aw_cur = aw_empty ? aw_push_data : aw_head;
    ar_cur = ar_empty ? ar_push_data : ar_head;

    w_beat_d = w_beat_q;
    w_done   = 1'b0;
    if (w_hs) begin
      if (aw_empty && !aw_hs) begin
        fire[CHK_W_NO_AW] = 1'b1;
      end else begin
        w_done = (w_beat_q == aw_cur.len);
        fire[CHK_WLAST] = (bus.wlast != w_done);
        w_beat_d = w_done ? '0 : w_beat_q + 8'd1;
      end
    end

    r_beat_d = r_beat_q;
    r_done   = 1'b0;
    if (r_hs) begin
      if (ar_empty && !ar_hs) begin
        fire[CHK_R_ORDER] = 1'b1;
      end else begin
        r_done = (r_beat_q == ar_cur.len);
        fire[CHK_RLAST]   = (bus.rlast != r_done);
        fire[CHK_R_ORDER] = (CHK_ID_MAX_W'(bus.rid) != ar_cur.id);
        r_beat_d = r_done ? '0 : r_beat_q + 8'd1;
      end
    end

    aw_pop  = w_done && !aw_empty;
    ar_pop  = r_done && !ar_empty;
    aw_over = aw_hs && aw_full && !aw_pop;
    ar_over = ar_hs && ar_full && !ar_pop;
    aw_push = aw_hs && !aw_over && !(aw_empty && w_done);
    ar_push = ar_hs && !ar_over && !(ar_empty && r_done);
    fire[CHK_OVERFLOW] = aw_over || ar_over;

    b_push = w_done;
    b_push_data.id  = aw_cur.id;
    b_push_data.len = '0;
    b_expect.id  = CHK_ID_MAX_W'(bus.bid);
    b_expect.len = '0;
    b_pop = b_hs && !b_empty && (b_head == b_expect);
    fire[CHK_B_ORDER] = b_hs && !b_pop;

    flags_d = flags_q | fire;
    pulse_d = |fire;
    count_d = count_q;
    if ((|fire) && (count_q != '1)) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_pend_q <= 1'b0; w_pend_q <= 1'b0; b_pend_q <= 1'b0;
      ar_pend_q <= 1'b0; r_pend_q <= 1'b0;
      aw_pl_q   <= '0; w_pl_q <= '0; b_pl_q <= '0; ar_pl_q <= '0; r_pl_q <= '0;
      w_beat_q  <= '0; r_beat_q <= '0;
      flags_q   <= '0; pulse_q <= 1'b0; count_q <= '0;
    end else begin
      aw_pend_q <= aw_pend_d; w_pend_q <= w_pend_d; b_pend_q <= b_pend_d;
      ar_pend_q <= ar_pend_d; r_pend_q <= r_pend_d;
      aw_pl_q   <= aw_pl_d; w_pl_q <= w_pl_d; b_pl_q <= b_pl_d;
      ar_pl_q   <= ar_pl_d; r_pl_q <= r_pl_d;
      w_beat_q  <= w_beat_d; r_beat_q <= r_beat_d;
      flags_q   <= flags_d; pulse_q <= pulse_d; count_q <= count_d;
    end
  end

  assign err_flags = flags_q;
  assign err_pulse = pulse_q;
  assign err_count = count_q;

  logic unused_b_full;
  assign unused_b_full = b_full;

endmodule

// File: tb/tb_axi_assertion_checker.sv
// Directed bench for axi_assertion_checker: legal traffic, each rule class,
// reset recovery and counter saturation, with hand-computed expectations.
module tb_axi_assertion_checker;
  import axi_chk_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_CHECKS-1:0] err_flags;
  logic        err_pulse;
  logic [15:0] err_count;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_assertion_checker_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

  axi_assertion_checker #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .MAX_OUT(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .err_flags(err_flags), .err_pulse(err_pulse), .err_count(err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [10:0] flags, input logic pulse,
                            input logic [15:0] count);
    check({tag, ".flags"}, 32'(err_flags), 32'(flags));
    check({tag, ".pulse"}, 32'(err_pulse), 32'(pulse));
    check({tag, ".count"}, 32'(err_count), 32'(count));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.awvalid = 1'b0; bus.awready = 1'b0;
    bus.wvalid  = 1'b0; bus.wready  = 1'b0; bus.wlast = 1'b0;
    bus.bvalid  = 1'b0; bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.arready = 1'b0;
    bus.rvalid  = 1'b0; bus.rready  = 1'b0; bus.rlast = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic aw_hs(input logic [3:0] id, input logic [7:0] len, input logic [31:0] addr);
    bus.awvalid = 1'b1; bus.awready = 1'b1;
    bus.awid = id; bus.awlen = len; bus.awaddr = addr;
    bus.awsize = 3'd2; bus.awburst = BURST_INCR;
    tick();
    bus.awvalid = 1'b0; bus.awready = 1'b0;
  endtask

  task automatic w_beat(input logic last);
    bus.wvalid = 1'b1; bus.wready = 1'b1; bus.wlast = last;
    bus.wdata = 32'($urandom()); bus.wstrb = 4'hF;
    tick();
    bus.wvalid = 1'b0; bus.wready = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic b_beat(input logic [3:0] id);
    bus.bvalid = 1'b1; bus.bready = 1'b1; bus.bid = id; bus.bresp = 2'b00;
    tick();
    bus.bvalid = 1'b0; bus.bready = 1'b0;
  endtask

  task automatic ar_hs(input logic [3:0] id, input logic [7:0] len);
    bus.arvalid = 1'b1; bus.arready = 1'b1;
    bus.arid = id; bus.arlen = len; bus.araddr = 32'h1000;
    bus.arsize = 3'd2; bus.arburst = BURST_INCR;
    tick();
    bus.arvalid = 1'b0; bus.arready = 1'b0;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic last);
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rid = id; bus.rlast = last;
    bus.rdata = 32'($urandom()); bus.rresp = 2'b00;
    tick();
    bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.wdata = '0; bus.wstrb = '0; bus.bid = '0; bus.bresp = '0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.rid = '0; bus.rdata = '0; bus.rresp = '0;

    // reset with noisy bus
    for (int i = 0; i < 3; i++) begin
      bus.awvalid = 1'($urandom()); bus.awready = 1'($urandom()); bus.awaddr = $urandom();
      bus.awid = 4'($urandom()); bus.awlen = 8'($urandom());
      bus.wvalid = 1'($urandom()); bus.wready = 1'($urandom()); bus.wlast = 1'($urandom());
      bus.wdata = $urandom();
      bus.bvalid = 1'($urandom()); bus.bready = 1'($urandom()); bus.bid = 4'($urandom());
      bus.arvalid = 1'($urandom()); bus.arready = 1'($urandom()); bus.arid = 4'($urandom());
      bus.rvalid = 1'($urandom()); bus.rready = 1'($urandom()); bus.rid = 4'($urandom());
      bus.rlast = 1'($urandom());
      tick();
    end
    check_outs("reset", 11'h000, 1'b0, 16'h0000);
    idle();
    rst = 1'b0;
    tick();
    check_outs("post_reset", 11'h000, 1'b0, 16'h0000);

    // legal write and read bursts of 4 beats
    aw_hs(4'd3, 8'd3, 32'h40);
    for (int i = 0; i < 4; i++) w_beat(i == 3);
    b_beat(4'd3);
    check_outs("legal_write", 11'h000, 1'b0, 16'h0000);
    ar_hs(4'd5, 8'd3);
    for (int i = 0; i < 4; i++) r_beat(4'd5, i == 3);
    check_outs("legal_read", 11'h000, 1'b0, 16'h0000);

    // AW payload changes while stalled
    bus.awvalid = 1'b1; bus.awready = 1'b0; bus.awid = 4'd2; bus.awlen = 8'd1;
    bus.awaddr = 32'h100;
    tick();
    check_outs("aw_stall", 11'h000, 1'b0, 16'h0000);
    bus.awready = 1'b1; bus.awaddr = 32'h104;
    tick();
    idle();
    check_outs("aw_unstable", 11'h001, 1'b1, 16'h0001);
    tick();
    check_outs("aw_unstable_after", 11'h001, 1'b0, 16'h0001);

    // early WLAST and wrong BID
    do_reset();
    check_outs("reset2", 11'h000, 1'b0, 16'h0000);
    aw_hs(4'd2, 8'd1, 32'h200);
    w_beat(1'b1);
    check_outs("wlast_early", 11'h020, 1'b1, 16'h0001);
    w_beat(1'b1);
    check_outs("wlast_final", 11'h020, 1'b0, 16'h0001);
    b_beat(4'd7);
    check_outs("bid_wrong", 11'h220, 1'b1, 16'h0002);
    b_beat(4'd2);
    check_outs("bid_right", 11'h220, 1'b0, 16'h0002);

    // AR overflow at depth 8, R ordering and RLAST
    do_reset();
    for (int i = 0; i < 8; i++) ar_hs(4'(i), 8'd0);
    check_outs("ar_fill8", 11'h000, 1'b0, 16'h0000);
    ar_hs(4'd8, 8'd0);
    check_outs("ar_overflow", 11'h400, 1'b1, 16'h0001);
    r_beat(4'd9, 1'b1);
    check_outs("rid_wrong", 11'h500, 1'b1, 16'h0002);
    r_beat(4'd1, 1'b1);
    check_outs("rid_next", 11'h500, 1'b0, 16'h0002);
    r_beat(4'd2, 1'b0);
    check_outs("rlast_missing", 11'h580, 1'b1, 16'h0003);
    r_beat(4'd3, 1'b1);
    check_outs("rid_after_pop", 11'h580, 1'b0, 16'h0003);

    // W with no AW plus B with empty b_q on one edge, then W drop while stalled
    do_reset();
    bus.wvalid = 1'b1; bus.wready = 1'b1; bus.wlast = 1'b1;
    bus.bvalid = 1'b1; bus.bready = 1'b1; bus.bid = 4'd0;
    tick();
    idle();
    check_outs("multi_rule", 11'h240, 1'b1, 16'h0001);
    bus.wvalid = 1'b1; bus.wready = 1'b0; bus.wdata = 32'hA5A5_0001;
    tick();
    idle();
    tick();
    check_outs("w_dropped", 11'h242, 1'b1, 16'h0002);

    // reset mid-write burst, then fresh legal write
    do_reset();
    aw_hs(4'd1, 8'd3, 32'h300);
    w_beat(1'b0);
    w_beat(1'b0);
    do_reset();
    aw_hs(4'd4, 8'd1, 32'h400);
    w_beat(1'b0);
    w_beat(1'b1);
    b_beat(4'd4);
    check_outs("reset_mid_burst", 11'h000, 1'b0, 16'h0000);

    // saturation: one B-order violation per edge
    bus.bvalid = 1'b1; bus.bready = 1'b1; bus.bid = 4'd0;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", 32'(err_count), 32'h0000_FFFE);
    tick();
    check("sat_ffff", 32'(err_count), 32'h0000_FFFF);
    tick();
    check_outs("sat_hold", 11'h200, 1'b1, 16'hFFFF);
    idle();
    tick();
    check_outs("sat_idle", 11'h200, 1'b0, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
